// File: rtl/bnn_test.sv
// bnn_test: self-contained two-layer binarized neural network smoke-test block.
//
// There are no data ports. A constant input vector IN_VEC is pushed through two
// registered XNOR/popcount layers every clock:
//   P1110 : layer-1 outputs, neuron j sees IN_VEC with weight row W1[j*N +: N]
//   P1120 : layer-2 outputs, neuron k sees P1110 with weight row W2[k*N +: N]
//   vld   : pipeline valid shift, vld[0] = layer 1 valid, vld[1] = layer 2 valid
// The register names are fixed so that benches can probe them hierarchically.
//
// Ports:
//   clk  - system clock, rising-edge active
//   rstn - asynchronous active-low reset, clears P1110, P1120 and vld

// Default weight generators. They live in a package so that the module header
// can use them as parameter defaults. The result is wider than needed and is
// size-cast down to N*N bits at the call site, so defaults cover N up to MAX_N.
// Larger N still works when W1/W2 are overridden explicitly.
package bnn_test_pkg;
  localparam int MAX_N = 256;
  localparam int MAX_W = MAX_N * MAX_N;

  // Layer-1 row j = (1 << j) - 1, i.e. the j low bits set.
  function automatic logic [MAX_W-1:0] default_w1(input int n);
    logic [MAX_W-1:0] w;
    w = '0;
    for (int j = 0; j < n && j < MAX_N; j++) begin
      for (int i = 0; i < j; i++) begin
        w[j*n + i] = 1'b1;
      end
    end
    return w;
  endfunction

  // Layer-2 rows alternate between "upper half set" (even rows) and
  // "lower half set" (odd rows); for n = 16 these are 16'hFF00 / 16'h00FF.
  function automatic logic [MAX_W-1:0] default_w2(input int n);
    logic [MAX_W-1:0] w;
    w = '0;
    for (int k = 0; k < n && k < MAX_N; k++) begin
      for (int i = 0; i < n; i++) begin
        w[k*n + i] = ((k % 2) == 0) ? (i >= n / 2) : (i < n / 2);
      end
    end
    return w;
  endfunction
endpackage

module bnn_test #(
  parameter int                N      = 16,
  parameter logic [N-1:0]      IN_VEC = '1,
  parameter logic [N*N-1:0]    W1     = (N*N)'(bnn_test_pkg::default_w1(N)),
  parameter int unsigned       TH1    = 8,
  parameter logic [N*N-1:0]    W2     = (N*N)'(bnn_test_pkg::default_w2(N)),
  parameter int unsigned       TH2    = 8
) (
  input logic clk,
  input logic rstn
);

  // Popcount width must hold the value N itself (all bits matching).
  localparam int CW = $clog2(N + 1);

  logic [N-1:0] P1110;
  logic [N-1:0] P1120;
  logic [1:0]   vld;

  logic [N-1:0] p1110_d;
  logic [N-1:0] p1120_d;
  logic [1:0]   vld_d;

  // One binarized neuron: count positions where input and weight agree
  // (XNOR), then fire when the match count reaches the threshold.
  function automatic logic neuron(input logic [N-1:0] x,
                                  input logic [N-1:0] w,
                                  input int unsigned  th);
    logic [N-1:0]  match;
    logic [CW-1:0] s;
    match = ~(x ^ w);
    s = '0;
    for (int i = 0; i < N; i++) begin
      s = s + CW'(match[i]);
    end
    return (32'(s) >= th);
  endfunction

  // Layer 2 reads the registered layer-1 result, never IN_VEC directly, so
  // each layer is a single clock-period path.
  always_comb begin
    p1110_d = '0;
    p1120_d = '0;
    vld_d   = {vld[0], 1'b1};
    for (int j = 0; j < N; j++) begin
      p1110_d[j] = neuron(IN_VEC, W1[j*N +: N], TH1);
    end
    for (int k = 0; k < N; k++) begin
      p1120_d[k] = neuron(P1110, W2[k*N +: N], TH2);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      P1110 <= '0;
      P1120 <= '0;
      vld   <= 2'b00;
    end else begin
      P1110 <= p1110_d;
      P1120 <= p1120_d;
      vld   <= vld_d;
    end
  end

endmodule

// File: tb/tb_bnn_test.sv
// tb_bnn_test: directed bench for bnn_test.
// Three instances share clock and reset: the default configuration, a
// threshold override (TH1 = 0, TH2 = 17) and an input override (IN_VEC = 0).
// Golden values are hand-derived from the XNOR/popcount definition.
module tb_bnn_test;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bnn_test u_dflt (
    .clk  (clk),
    .rstn (rstn)
  );

  bnn_test #(
    .TH1 (0),
    .TH2 (17)
  ) u_th (
    .clk  (clk),
    .rstn (rstn)
  );

  bnn_test #(
    .IN_VEC (16'h0000)
  ) u_zero (
    .clk  (clk),
    .rstn (rstn)
  );

  // Golden results for the default instance:
  // layer 1 row j has j ones, all match IN_VEC = FFFF -> bit j = (j >= 8).
  // layer 2 input FF00: even rows (FF00) match 16, odd rows (00FF) match 0.
  localparam logic [15:0] GOLD_L1 = 16'hFF00;
  localparam logic [15:0] GOLD_L2 = 16'h5555;

  // Reset held from time zero: every register of every instance is zero,
  // including across a clock edge that arrives while reset is low.
  task automatic test_reset();
    #2;
    checks++;
    if (u_dflt.P1110 !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_p1110 actual=%h required=%h", u_dflt.P1110, 16'h0000);
    end
    checks++;
    if (u_dflt.P1120 !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_p1120 actual=%h required=%h", u_dflt.P1120, 16'h0000);
    end
    @(posedge clk);
    #1;
    checks++;
    if (u_dflt.vld !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_vld actual=%b required=%b", u_dflt.vld, 2'b00);
    end
    checks++;
    if (u_zero.P1110 !== 16'h0000 || u_th.P1110 !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_other_p1110 actual=%h/%h required=0000/0000",
               u_th.P1110, u_zero.P1110);
    end
  endtask

  // Release reset on a falling edge and walk the two-edge fill of the pipeline.
  task automatic test_release_sequence(input string tag);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (u_dflt.P1110 !== GOLD_L1) begin
      errors++;
      $display("[TB] FAIL %s_edge1_p1110 actual=%h required=%h", tag, u_dflt.P1110, GOLD_L1);
    end
    checks++;
    if (u_dflt.vld !== 2'b01) begin
      errors++;
      $display("[TB] FAIL %s_edge1_vld actual=%b required=%b", tag, u_dflt.vld, 2'b01);
    end
    @(posedge clk);
    #1;
    checks++;
    if (u_dflt.P1120 !== GOLD_L2) begin
      errors++;
      $display("[TB] FAIL %s_edge2_p1120 actual=%h required=%h", tag, u_dflt.P1120, GOLD_L2);
    end
    checks++;
    if (u_dflt.vld !== 2'b11) begin
      errors++;
      $display("[TB] FAIL %s_edge2_vld actual=%b required=%b", tag, u_dflt.vld, 2'b11);
    end
    checks++;
    if (u_dflt.P1110 !== GOLD_L1) begin
      errors++;
      $display("[TB] FAIL %s_edge2_p1110 actual=%h required=%h", tag, u_dflt.P1110, GOLD_L1);
    end
  endtask

  // Constant inputs: results must hold for 100 consecutive cycles.
  task automatic test_steady_state();
    int bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checks++;
      if (u_dflt.P1110 !== GOLD_L1 || u_dflt.P1120 !== GOLD_L2 || u_dflt.vld !== 2'b11) begin
        errors++;
        if (bad < 5) begin
          $display("[TB] FAIL steady_cycle%0d actual=%h/%h/%b required=%h/%h/%b", c,
                   u_dflt.P1110, u_dflt.P1120, u_dflt.vld, GOLD_L1, GOLD_L2, 2'b11);
        end
        bad++;
      end
    end
  endtask

  // Reset dropped between edges must clear everything without waiting for clk.
  task automatic test_async_reset();
    repeat (20) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    checks++;
    if (u_dflt.P1110 !== 16'h0000 || u_dflt.P1120 !== 16'h0000 || u_dflt.vld !== 2'b00) begin
      errors++;
      $display("[TB] FAIL async_clear actual=%h/%h/%b required=0000/0000/00",
               u_dflt.P1110, u_dflt.P1120, u_dflt.vld);
    end
    checks++;
    if (u_zero.P1110 !== 16'h0000 || u_th.P1120 !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL async_clear_other actual=%h/%h required=0000/0000",
               u_zero.P1110, u_th.P1120);
    end
    @(posedge clk);
    #1;
    checks++;
    if (u_dflt.P1110 !== 16'h0000 || u_dflt.vld !== 2'b00) begin
      errors++;
      $display("[TB] FAIL async_hold actual=%h/%b required=0000/00", u_dflt.P1110, u_dflt.vld);
    end
  endtask

  // Parameter overrides, checked once the pipeline is full.
  // u_th : TH1 = 0 fires every layer-1 neuron; TH2 = 17 exceeds N so none fire.
  // u_zero: row j matches 16 - j zeros -> bit j = (j <= 8) -> 01FF;
  //         even rows (FF00) match 1, odd rows (00FF) match 15 -> AAAA.
  task automatic test_overrides();
    repeat (3) @(negedge clk);
    checks++;
    if (u_th.P1110 !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL th_p1110 actual=%h required=%h", u_th.P1110, 16'hFFFF);
    end
    checks++;
    if (u_th.P1120 !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL th_p1120 actual=%h required=%h", u_th.P1120, 16'h0000);
    end
    checks++;
    if (u_zero.P1110 !== 16'h01FF) begin
      errors++;
      $display("[TB] FAIL zero_p1110 actual=%h required=%h", u_zero.P1110, 16'h01FF);
    end
    checks++;
    if (u_zero.P1120 !== 16'hAAAA) begin
      errors++;
      $display("[TB] FAIL zero_p1120 actual=%h required=%h", u_zero.P1120, 16'hAAAA);
    end
    checks++;
    if (u_zero.vld !== 2'b11 || u_th.vld !== 2'b11) begin
      errors++;
      $display("[TB] FAIL override_vld actual=%b/%b required=11/11", u_th.vld, u_zero.vld);
    end
  endtask

  initial begin
    test_reset();
    test_release_sequence("first");
    test_steady_state();
    test_async_reset();
    test_release_sequence("rerun");
    test_overrides();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
